// File: rtl/grant_decoder.sv
// Binary-to-one-hot grant decoder with valid/ready request intake.
// Optional grant watchdog enabled by defining GRANT_DECODER_TIMEOUT_EN.
module grant_decoder #(
    parameter int OUTPUT_WIDTH   = 4,
    parameter int ENC_WIDTH      = $clog2(OUTPUT_WIDTH),
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    req_valid,
    input  logic [ENC_WIDTH-1:0]    req_encoded,
    output logic                    req_ready,
    output logic [OUTPUT_WIDTH-1:0] grant_onehot,
    output logic [ENC_WIDTH-1:0]    grant_encoded,
    output logic                    grant_valid,
    input  logic                    grant_release,
    output logic                    decode_error,
    output logic                    timeout
);

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    localparam logic [ENC_WIDTH:0] PORTS = (ENC_WIDTH + 1)'(OUTPUT_WIDTH);

    state_t state;
    logic   in_range;
    logic   accept;
    logic   expired;

    assign in_range = {1'b0, req_encoded} < PORTS;
    assign accept   = req_valid && req_ready;

`ifdef GRANT_DECODER_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

    logic [CNT_W-1:0] wd_cnt;

    // A coincident release wins over the watchdog.
    assign expired = (state == GRANT) && (wd_cnt == LIMIT) && !grant_release;

    // Watchdog counts GRANT cycles; idles at zero so each grant starts fresh.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wd_cnt  <= '0;
            timeout <= 1'b0;
        end else begin
            timeout <= expired;
            if (state == GRANT) begin
                wd_cnt <= wd_cnt + 1'b1;
            end else begin
                wd_cnt <= '0;
            end
        end
    end
`else
    assign expired = 1'b0;
    assign timeout = 1'b0;
`endif

    // Grant FSM with all handshake and grant outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= IDLE;
            req_ready     <= 1'b1;
            grant_onehot  <= '0;
            grant_encoded <= '0;
            grant_valid   <= 1'b0;
            decode_error  <= 1'b0;
        end else begin
            decode_error <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        if (in_range) begin
                            state         <= GRANT;
                            req_ready     <= 1'b0;
                            grant_onehot  <= OUTPUT_WIDTH'(1) << req_encoded;
                            grant_encoded <= req_encoded;
                            grant_valid   <= 1'b1;
                        end else begin
                            decode_error <= 1'b1;
                        end
                    end
                end
                GRANT: begin
                    if (grant_release || expired) begin
                        state        <= IDLE;
                        req_ready    <= 1'b1;
                        grant_onehot <= '0;
                        grant_valid  <= 1'b0;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_grant_decoder.sv
// Randomized self-checking bench for grant_decoder against a
// cycle-level behavioural model of the grant rules.
module tb_grant_decoder;

    localparam int W  = 5;
    localparam int EW = 3;
    localparam int T  = 8;
`ifdef GRANT_DECODER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req_valid = 1'b0;
    logic [EW-1:0] req_encoded = '0;
    logic          req_ready;
    logic [W-1:0]  grant_onehot;
    logic [EW-1:0] grant_encoded;
    logic          grant_valid;
    logic          grant_release = 1'b0;
    logic          decode_error;
    logic          timeout;

    int total = 0;
    int bad   = 0;

    // model: held port (-1 none), cycles held, last granted index, pulses
    int held  = -1;
    int age   = 0;
    int last  = 0;
    bit m_err = 1'b0;
    bit m_to  = 1'b0;

    always #5 clk = ~clk;

    grant_decoder #(
        .OUTPUT_WIDTH  (W),
        .ENC_WIDTH     (EW),
        .TIMEOUT_CYCLES(T)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .req_valid    (req_valid),
        .req_encoded  (req_encoded),
        .req_ready    (req_ready),
        .grant_onehot (grant_onehot),
        .grant_encoded(grant_encoded),
        .grant_valid  (grant_valid),
        .grant_release(grant_release),
        .decode_error (decode_error),
        .timeout      (timeout)
    );

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        held  = -1;
        age   = 0;
        last  = 0;
        m_err = 1'b0;
        m_to  = 1'b0;
    endtask

    task automatic model_edge(input bit v, input int e, input bit r);
        m_err = 1'b0;
        m_to  = 1'b0;
        if (held < 0) begin
            if (v) begin
                if (e < W) begin
                    held = e;
                    last = e;
                    age  = 0;
                end else begin
                    m_err = 1'b1;
                end
            end
        end else if (r) begin
            held = -1;
        end else if (TO_EN && age + 1 == T) begin
            held = -1;
            m_to = 1'b1;
        end else begin
            age++;
        end
    endtask

    task automatic compare_all(input string tag);
        int oh;
        oh = (held >= 0) ? (1 << held) : 0;
        check({tag, ":onehot"}, 32'(grant_onehot), oh);
        check({tag, ":gvalid"}, 32'(grant_valid), (held >= 0) ? 1 : 0);
        check({tag, ":ready"}, 32'(req_ready), (held < 0) ? 1 : 0);
        check({tag, ":genc"}, 32'(grant_encoded), last);
        check({tag, ":derr"}, 32'(decode_error), 32'(m_err));
        check({tag, ":tmo"}, 32'(timeout), 32'(m_to));
    endtask

    task automatic step(input string tag, input bit v, input int e,
                        input bit r);
        @(negedge clk);
        req_valid     = v;
        req_encoded   = EW'(e);
        grant_release = r;
        @(posedge clk);
        model_edge(v, e, r);
        #1;
        compare_all(tag);
    endtask

    initial begin
        model_reset();
        #12;
        compare_all("reset");
        @(negedge clk);
        rst = 1'b0;

        step("grant2", 1'b1, 2, 1'b0);
        repeat (10) step("hold", 1'b1, 1, 1'b0);
        step("release", 1'b0, 0, 1'b1);
        step("gap", 1'b1, 1, 1'b0);
        step("grant1", 1'b0, 0, 1'b0);
        step("rel1", 1'b0, 0, 1'b1);

        step("bad6", 1'b1, 6, 1'b0);
        step("bad7", 1'b1, 7, 1'b0);
        step("badend", 1'b0, 0, 1'b1);
        step("edge4", 1'b1, 4, 1'b0);
        step("rel4", 1'b0, 0, 1'b1);

        step("grant0", 1'b1, 0, 1'b0);
        @(negedge clk);
        req_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        model_reset();
        compare_all("arst");
        @(negedge clk);
        rst         = 1'b0;
        req_valid   = 1'b1;
        req_encoded = 3'd3;
        @(posedge clk);
        model_edge(1'b1, 3, 1'b0);
        #1;
        compare_all("first");

        step("rel3", 1'b0, 0, 1'b1);
        step("wd3", 1'b1, 3, 1'b0);
        repeat (T + 2) step("wdhold", 1'b0, 0, 1'b0);
        step("wdrel", 1'b0, 0, 1'b1);
        step("idle", 1'b0, 0, 1'b0);

        step("lim1", 1'b1, 1, 1'b0);
        repeat (T - 1) step("limhold", 1'b0, 0, 1'b0);
        step("limrel", 1'b0, 0, 1'b1);
        step("limpost", 1'b0, 0, 1'b0);

        for (int i = 0; i < 600; i++) begin
            step("rand", 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                 ($urandom_range(0, 5) == 0));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/grant_decoder.md
# grant_decoder

Sequential binary-to-one-hot grant decoder for the AXI interconnect arbitration path, the receiving end of the priority encoder's encoded output. It accepts an encoded port index with a valid/ready handshake, drives a registered one-hot grant to the selected port, and holds it until the port releases it. Out-of-range indices are rejected and flagged. An optional watchdog forcibly revokes stuck grants.

## Interface
- `OUTPUT_WIDTH`, default 4: number of grantable ports, ≥ 2.
- `ENC_WIDTH`, default `$clog2(OUTPUT_WIDTH)`: width of the encoded index.
- `TIMEOUT_CYCLES`, default 256: grant watchdog limit, ≥ 2. Used only with `GRANT_DECODER_TIMEOUT_EN`.
- `clk`, in, 1: single clock; all logic rising-edge.
- `rst`, in, 1: asynchronous, active-high reset.
- `req_valid`, in, 1: encoded request present.
- `req_encoded`, in, `ENC_WIDTH`: port index to grant.
- `req_ready`, out, 1: decoder can accept a request.
- `grant_onehot`, out, `OUTPUT_WIDTH`: registered one-hot grant.
- `grant_encoded`, out, `ENC_WIDTH`: registered index of the current grant.
- `grant_valid`, out, 1: a grant is held.
- `grant_release`, in, 1: granted port has finished; sampled only while `grant_valid`=1.
- `decode_error`, out, 1: one-cycle pulse when an out-of-range index is rejected.
- `timeout`, out, 1: one-cycle pulse when the watchdog revokes a grant.

## Operation
- Reset values: FSM = IDLE, `req_ready`=1, `grant_onehot`=0, `grant_encoded`=0, `grant_valid`=0, `decode_error`=0, `timeout`=0, watchdog counter = 0.
- IDLE state:
  - `req_ready`=1.
  - On `req_valid`=1 with `req_encoded` < `OUTPUT_WIDTH`: latch the index, register `grant_onehot` = 1 << index, set `grant_valid`, go to GRANT.
  - On `req_valid`=1 with `req_encoded` ≥ `OUTPUT_WIDTH`: the request is consumed. Pulse `decode_error` the next cycle, stay in IDLE, no grant.
- GRANT state:
  - `req_ready`=0. `grant_onehot` and `grant_encoded` stay stable.
  - `req_valid` is ignored and is not consumed.
  - On `grant_release`=1: clear `grant_onehot` and `grant_valid`, return to IDLE.
- `grant_release` while in IDLE is ignored.
- Invariants:
  - `grant_onehot` is always all-zero or exactly one-hot.
  - `grant_valid` == |`grant_onehot`.
- The handshake is a transfer only when `req_valid` && `req_ready`. There is no combinational path from `req_valid` to `req_ready`.

## Timing
- Request latency: handshake at edge N produces `grant_onehot`/`grant_valid` after edge N (visible in cycle N+1).
- Release: `grant_release` sampled at edge M → grant clears and `req_ready`=1 after edge M.
- Back-to-back grants: a new request can be accepted at edge M+1 and granted after it. The one-cycle all-zero grant gap is mandatory.
- `decode_error` is high for exactly the one cycle after the rejecting edge. A back-to-back bad request is accepted in that same cycle.
- Reset mid-grant: `rst` asserted clears all outputs immediately (asynchronously), with no release required.
- Reset deassertion: the first accepted request is at the first rising edge with `rst`=0.

## Configuration
- Macro `GRANT_DECODER_TIMEOUT_EN`.
- Defined:
  - A `$clog2(TIMEOUT_CYCLES)`-bit counter clears on entry to GRANT and increments each GRANT cycle.
  - When it reaches `TIMEOUT_CYCLES`-1 without `grant_release`, the grant is cleared and the FSM returns to IDLE on that edge, with `timeout` pulsed the following cycle.
  - The grant is therefore held exactly `TIMEOUT_CYCLES` cycles.
  - If `grant_release` and the limit coincide, it is treated as a release: no `timeout`.
- Undefined: no counter is built, `timeout` is tied 0, and a grant is held indefinitely.

## Test plan
- Reset then `req_encoded`=2, `req_valid`=1 for one cycle → next cycle `grant_onehot`=4'b0100, `grant_encoded`=2, `grant_valid`=1, `req_ready`=0.
- Hold grant 10 cycles while driving `req_valid`=1, `req_encoded`=1 → grant stays 4'b0100; request not consumed. Then `grant_release` pulse → one cycle grant 0 / `req_ready`=1, then `grant_onehot`=4'b0010.
- `OUTPUT_WIDTH`=3, `req_encoded`=3 → `decode_error`=1 for one cycle, `grant_valid` stays 0, `req_ready` stays 1.
- Assert `rst` asynchronously (between edges) while granting port 0 → `grant_onehot`=0, `grant_valid`=0, `req_ready`=1 without waiting for a clock edge.
- With `GRANT_DECODER_TIMEOUT_EN` and `TIMEOUT_CYCLES`=8, grant port 3 and never release → grant high exactly 8 cycles, then `timeout`=1 for one cycle and `req_ready`=1.
- Same configuration, release on the 8th grant cycle → grant clears with `timeout`=0.
